// File: rtl/chanel_result_fifo.sv
// Result FIFO between the channel postprocessor and the host readout.
// First-word-fall-through with a registered head word, a sticky overflow flag and an occupancy count.
module chanel_result_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_rdy,
  input  logic             i_clr_ovf,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data,
  output logic [AW:0]      o_cnt,
  output logic             o_full,
  output logic             o_ovf
);

  localparam int unsigned DEPTH   = 1 << AW;
  localparam logic [AW:0] CntFull = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q, rptr_nxt;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] data_d;
  logic             full, rd, wr, drop;

  assign full     = (cnt_q == CntFull);
  assign rd       = o_vld & i_rdy;
  assign wr       = i_vld & (~full | rd);
  assign drop     = i_vld & full & ~rd;
  assign rptr_nxt = rptr_q + AW'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (wr && !rd) begin
      cnt_d = cnt_q + (AW + 1)'(1);
    end else if (rd && !wr) begin
      cnt_d = cnt_q - (AW + 1)'(1);
    end
  end

  // The memory slot at rptr_q is the word shown on o_data; the next head comes either from
  // the slot after it or, when the FIFO would otherwise be empty, straight from the input.
  always_comb begin
    data_d = o_data;
    if (rd) begin
      if (cnt_q == (AW + 1)'(1)) begin
        if (wr) begin
          data_d = i_data;
        end
      end else begin
        data_d = mem[rptr_nxt];
      end
    end else if (!o_vld && wr) begin
      data_d = i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr_q] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      o_vld  <= 1'b0;
      o_data <= '0;
      o_ovf  <= 1'b0;
    end else begin
      if (wr) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (rd) begin
        rptr_q <= rptr_nxt;
      end
      cnt_q  <= cnt_d;
      o_vld  <= (cnt_d != '0);
      o_data <= data_d;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        o_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        o_ovf <= 1'b0;
      end
    end
  end

  assign o_cnt  = cnt_q;
  assign o_full = full;

endmodule

// File: tb/tb_chanel_result_fifo.sv
// Directed bench for chanel_result_fifo: per-cycle vector table plus hand-written
// wrap-around and asynchronous-reset sequences.
module tb_chanel_result_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_vld = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_rdy = 1'b0;
  logic        i_clr_ovf = 1'b0;
  logic        o_vld;
  logic [31:0] o_data;
  logic [3:0]  o_cnt;
  logic        o_full;
  logic        o_ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  chanel_result_fifo #(
    .WIDTH(32),
    .AW   (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_vld    (i_vld),
    .i_data   (i_data),
    .i_rdy    (i_rdy),
    .i_clr_ovf(i_clr_ovf),
    .o_vld    (o_vld),
    .o_data   (o_data),
    .o_cnt    (o_cnt),
    .o_full   (o_full),
    .o_ovf    (o_ovf)
  );

  typedef struct {
    string       name;
    logic        vld;
    logic [31:0] data;
    logic        rdy;
    logic        clr;
    logic        e_vld;
    logic [31:0] e_data;
    logic [3:0]  e_cnt;
    logic        e_full;
    logic        e_ovf;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input string name, input logic v, input logic [31:0] d,
                              input logic r, input logic c, input logic ev,
                              input logic [31:0] ed, input int ec, input logic eo);
    vec_t t;
    t.name   = name;
    t.vld    = v;
    t.data   = d;
    t.rdy    = r;
    t.clr    = c;
    t.e_vld  = ev;
    t.e_data = ed;
    t.e_cnt  = 4'(ec);
    t.e_full = (ec == 8);
    t.e_ovf  = eo;
    vq.push_back(t);
  endfunction

  task automatic check(input string name, input logic ev, input logic [31:0] ed,
                       input logic [3:0] ec, input logic ef, input logic eo);
    tests++;
    if (o_vld !== ev || (ev && o_data !== ed) || o_cnt !== ec || o_full !== ef ||
        o_ovf !== eo) begin
      fails++;
      $display("FAIL %s: got vld=%b data=%h cnt=%0d full=%b ovf=%b, want vld=%b data=%h cnt=%0d full=%b ovf=%b",
               name, o_vld, o_data, o_cnt, o_full, o_ovf, ev, ed, ec, ef, eo);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic c);
    @(negedge clk);
    i_vld     = v;
    i_data    = d;
    i_rdy     = r;
    i_clr_ovf = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_n;
    int sent;
    int cyc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 1'b0, '0, 4'd0, 1'b0, 1'b0);
    tests++;
    if (o_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: got %h want 00000000", o_data);
    end
    @(negedge clk);
    rst = 1'b0;

    // Pass-through
    add("pass_in", 1, 32'h1234, 1, 0, 1, 32'h1234, 1, 0);
    add("pass_out", 0, 0, 1, 0, 0, 0, 0, 0);
    // Fill past full, then drain
    for (int k = 1; k <= 10; k++) add("fill", 1, 32'(k), 0, 0, 1, 1, (k <= 8) ? k : 8, k > 8);
    for (int j = 1; j <= 8; j++) add("drain", 0, 0, 1, 0, j < 8, 32'(j + 1), 8 - j, 1);
    add("clr_ovf", 0, 0, 0, 1, 0, 0, 0, 0);
    // Full with simultaneous read and write
    for (int k = 1; k <= 8; k++) add("fill2", 1, 32'(k), 0, 0, 1, 1, k, 0);
    add("full_rw", 1, 99, 1, 0, 1, 2, 8, 0);
    for (int j = 1; j <= 8; j++)
      add("drain2", 0, 0, 1, 0, j < 8, (j <= 6) ? 32'(j + 2) : 32'd99, 8 - j, 0);
    // Drop and clear in the same cycle: set wins
    for (int k = 1; k <= 8; k++) add("fill3", 1, 32'(100 + k), 0, 0, 1, 101, k, 0);
    add("drop_clr", 1, 32'hdead, 0, 1, 1, 101, 8, 1);
    add("clr_only", 0, 0, 0, 1, 1, 101, 8, 0);
    for (int j = 1; j <= 8; j++) add("drain3", 0, 0, 1, 0, j < 8, 32'(101 + j), 8 - j, 0);

    foreach (vq[i]) begin
      drive(vq[i].vld, vq[i].data, vq[i].rdy, vq[i].clr);
      check(vq[i].name, vq[i].e_vld, vq[i].e_data, vq[i].e_cnt, vq[i].e_full, vq[i].e_ovf);
    end

    // Wrap-around: prefill 4, then write and read together on alternate cycles
    exp_n = 0;
    sent  = 0;
    cyc   = 0;
    while (exp_n < 20 && cyc < 200) begin
      @(negedge clk);
      if (cyc < 4) begin
        i_rdy = 1'b0;
        i_vld = 1'b1;
      end else begin
        i_rdy = cyc[0];
        i_vld = i_rdy && (sent < 20);
      end
      i_data    = 32'(sent);
      i_clr_ovf = 1'b0;
      if (i_vld) sent++;
      tests++;
      if (o_cnt > 4'd8 || o_ovf !== 1'b0) begin
        fails++;
        $display("FAIL wrap_cnt: got cnt=%0d ovf=%b want cnt<=8 ovf=0", o_cnt, o_ovf);
      end
      if (o_vld && i_rdy) begin
        tests++;
        if (o_data !== 32'(exp_n)) begin
          fails++;
          $display("FAIL wrap_order: got %0d want %0d", o_data, exp_n);
        end
        exp_n++;
      end
      @(posedge clk);
      cyc++;
    end
    tests++;
    if (exp_n != 20) begin
      fails++;
      $display("FAIL wrap_count: got %0d words want 20", exp_n);
    end
    drive(0, 0, 0, 0);
    check("wrap_empty", 0, 0, 0, 0, 0);

    // Asynchronous reset with 5 words stored and overflow set
    for (int k = 1; k <= 9; k++) drive(1, 32'(200 + k), 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    check("pre_rst", 1, 204, 5, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 32'hA5, 0, 0);
    check("post_rst", 1, 32'hA5, 1, 0, 0);
    drive(0, 0, 1, 0);
    check("post_rst_rd", 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chanel_result_fifo.md
Name: chanel_result_fifo

Overview:
- Buffers the averaged per-channel results that the channel postprocessor emits as single-cycle valid pulses.
- Presents them to the downstream host/readout interface with a valid/ready handshake.
- The input side has no backpressure, so a full buffer drops samples and raises a sticky overflow flag.
- Also reports the occupancy level.

Parameters:
- WIDTH, 32, data word width; matches the postprocessor output width.
- AW, 3, address width; FIFO depth is 2**AW entries (AW >= 1).

Ports:
- clk  input  1  single clock for the block.
- rst  input  1  asynchronous reset, active-high; deassert synchronously externally.
- i_vld  input  1  input sample strobe; one word per asserted cycle.
- i_data  input  WIDTH  input sample.
- i_rdy  input  1  downstream ready.
- i_clr_ovf  input  1  synchronous clear of the o_ovf flag.
- o_vld  output  1  output word valid.
- o_data  output  WIDTH  output word; head of the FIFO.
- o_cnt  output  AW+1  number of stored words, including the one presented on o_data.
- o_full  output  1  o_cnt == 2**AW.
- o_ovf  output  1  sticky overflow flag.

Behaviour:
- Reset values (rst high, asynchronous):
  - o_vld=0, o_data=0, o_cnt=0, o_full=0, o_ovf=0.
  - Read and write pointers = 0.
  - Memory contents are don't-care.
- Storage:
  - Circular buffer of 2**AW words, wptr/rptr of AW bits, wrapping modulo 2**AW.
  - Count register of AW+1 bits.
  - Empty when cnt==0, full when cnt==2**AW.
- Write: wr = i_vld & (~full | rd). A word is written at wptr on the clock edge, then wptr increments.
- Read: rd = o_vld & i_rdy. On the clock edge rptr increments.
- Count update:
  - cnt += 1 when wr & ~rd.
  - cnt -= 1 when rd & ~wr.
  - cnt unchanged when both or neither.
- Full with simultaneous read and write: the write is accepted and the count stays at 2**AW. No drop and no overflow.
- Empty with simultaneous write: the word is stored and cnt=1. The read cannot occur because o_vld=0.
- Output is first-word-fall-through with registered outputs:
  - o_vld/o_data are registers.
  - A word written into an empty FIFO appears with o_vld=1 on the cycle after the write edge. Write-to-output latency is 1 clock.
  - o_data holds stable while o_vld=1 and i_rdy=0.
  - After an accepted read, the next word (if any) is presented on the following cycle with no bubble. Back-to-back reads at 1 word/clock are sustainable.
  - When the last word is read and no write occurs, o_vld drops the next cycle.
- Derived outputs: o_cnt and o_full come from the registered count and are valid in the same cycle as the count they describe.
- Overflow:
  - Condition: i_vld & full & ~rd drops the input word.
  - The write pointer and contents are untouched.
  - o_ovf is set the next cycle.
  - i_clr_ovf clears o_ovf. If a drop and a clear occur in the same cycle, set wins and o_ovf stays 1.
- Reset mid-operation: all state is cleared immediately. Words in flight are lost and o_vld falls without waiting for a clock.
- No X propagation: o_data is not updated while empty.

Test Plan:
- Basic pass-through:
  - Stimulus: reset; AW=3; i_rdy=1; single i_vld pulse with i_data=32'h0000_1234.
  - Required: o_vld=1 and o_data=32'h1234 exactly one cycle later for one cycle; o_cnt returns to 0; o_ovf stays 0.
- Fill and overflow:
  - Stimulus: i_rdy=0; write 10 consecutive words 1..10.
  - Required: o_full=1 after word 8 and o_cnt=8; words 9 and 10 are dropped; o_ovf=1.
  - Then: i_rdy=1 drains exactly 1..8 in order on consecutive cycles.
- Full with simultaneous read and write:
  - Stimulus: FIFO full with 1..8; assert i_vld with data 99 while i_rdy=1 in the same cycle.
  - Required: o_ovf stays 0; o_cnt stays 8; the drained sequence is 1..8,99.
- Wrap-around:
  - Stimulus: 20 words 0..19 streamed with i_rdy toggling in a 1-on/1-off pattern, never overflowing.
  - Required: output order is exactly 0..19; o_cnt never exceeds 8.
- Overflow clear priority:
  - Stimulus: assert i_clr_ovf in the same cycle as a dropped write.
  - Required: o_ovf=1.
  - Then: i_clr_ovf alone gives o_ovf=0 the next cycle.
- Asynchronous reset mid-stream:
  - Stimulus: assert rst between clock edges while 5 words are stored.
  - Required: o_vld, o_cnt and o_ovf go to 0 immediately; after release, a new write of 32'hA5 is output first.
